level_update_scheduler: RTL and testbench

- Frame-synchronous controller that owns the water_level register driving the VGA tank graphic.
- Accepts three requesters: pour (increment), drink (decrement) and clear. It arbitrates between them and commits at most one level change per video frame, during vertical sync. The display therefore never shows a partially updated tank.
- Also generates the empty-tank blink flag consumed by the remainder indicator.
- Sits between the button/timer logic and videoGen, in the clk domain.

---
 rtl/level_pkg.sv | 42 ++++
 rtl/level_update_scheduler_if.sv | 26 ++
 rtl/level_update_scheduler_vsync_edge_sync.sv | 30 +++
 rtl/level_update_scheduler.sv | 148 ++++++++++++++
 tb/tb_level_update_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/level_pkg.sv
// Shared definitions for the level update scheduler: FSM states,
// requester bit positions, level width and the request arbiter.
package level_pkg;

    localparam int LEVEL_W = 4;
    localparam int REQ_W   = 3;

    // Bit positions inside the {clr,dec,inc} request/pending/grant vectors
    localparam int REQ_INC = 0;
    localparam int REQ_DEC = 1;
    localparam int REQ_CLR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic [REQ_W-1:0] req_vec_t;

    // Pick one winner from the pending flags. Clear always wins; inc and
    // dec take turns when both are waiting, steered by prefer_dec.
    function automatic req_vec_t arbitrate(input req_vec_t pend, input logic prefer_dec);
        req_vec_t win;
        win = '0;
        if (pend[REQ_CLR]) begin
            win[REQ_CLR] = 1'b1;
        end else if (pend[REQ_INC] && pend[REQ_DEC]) begin
            if (prefer_dec) begin
                win[REQ_DEC] = 1'b1;
            end else begin
                win[REQ_INC] = 1'b1;
            end
        end else if (pend[REQ_INC]) begin
            win[REQ_INC] = 1'b1;
        end else if (pend[REQ_DEC]) begin
            win[REQ_DEC] = 1'b1;
        end
        return win;
    endfunction

endpackage

// File: rtl/level_update_scheduler_if.sv
// Request/status bundle between the button/timer logic and the scheduler.
// master = requester side, slave = scheduler side.
interface level_update_scheduler_if;
    import level_pkg::*;

    logic               req_inc;
    logic               req_dec;
    logic               req_clr;
    logic [LEVEL_W-1:0] water_level;
    logic [REQ_W-1:0]   pending;
    logic [REQ_W-1:0]   grant;
    logic               frame_tick;
    logic               empty;
    logic               blink;

    modport master (
        output req_inc, req_dec, req_clr,
        input  water_level, pending, grant, frame_tick, empty, blink
    );

    modport slave (
        input  req_inc, req_dec, req_clr,
        output water_level, pending, grant, frame_tick, empty, blink
    );

endinterface

// File: rtl/level_update_scheduler_vsync_edge_sync.sv
// Brings the active-low vsync from the pixel clock into clk and emits a
// one-cycle frame_tick on each assertion (synced 1->0 transition).
module vsync_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic sync1_reg;
    logic sync2_reg;
    logic hist_reg;

    // Two-flop synchronizer plus history; all preset to 1 (vsync idle level)
    // so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            hist_reg  <= 1'b1;
        end else begin
            sync1_reg <= vsync;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign frame_tick = hist_reg & ~sync2_reg;

endmodule

// File: rtl/level_update_scheduler.sv
// Owns water_level for the tank graphic. Requests are latched as pending
// flags; once per frame (at vsync) one of them is arbitrated and committed,
// so the display never sees a half-updated tank. Also drives the
// empty-tank blink flag.
module level_update_scheduler
    import level_pkg::*;
#(
    parameter int MAX_LEVEL    = 15,
    parameter int INIT_LEVEL   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    level_update_scheduler_if.slave bus
);

    localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] INIT_L = LEVEL_W'(INIT_LEVEL);
    localparam int                 CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic               frame_tick;
    req_vec_t           req_vec;
    req_vec_t           grant_vec;

    state_t             state_reg, state_next;
    req_vec_t           winner_reg, winner_next;
    req_vec_t           pending_reg, pending_next;
    logic               prefer_dec_reg, prefer_dec_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [CNT_W-1:0]   blink_cnt_reg, blink_cnt_next;
    logic               blink_reg, blink_next;

    vsync_edge_sync u_vsync_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign req_vec[REQ_INC] = bus.req_inc;
    assign req_vec[REQ_DEC] = bus.req_dec;
    assign req_vec[REQ_CLR] = bus.req_clr;

    // The winner is only shown during the COMMIT cycle
    assign grant_vec = (state_reg == COMMIT) ? winner_reg : '0;

    // Per-requester flag: a new pulse sets it even in the cycle its grant
    // would clear it, so a request landing on the commit edge is kept.
    generate
        for (genvar gi = 0; gi < REQ_W; gi++) begin : g_pending
            assign pending_next[gi] = req_vec[gi] | (pending_reg[gi] & ~grant_vec[gi]);
        end
    endgenerate

    // FSM next state and winner selection
    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        case (state_reg)
            IDLE: begin
                if (frame_tick) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (pending_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    winner_next = arbitrate(pending_reg, prefer_dec_reg);
                    state_next  = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Level update and round-robin pointer, applied on the COMMIT edge only
    always_comb begin
        level_next      = level_reg;
        prefer_dec_next = prefer_dec_reg;
        if (grant_vec[REQ_CLR]) begin
            level_next = '0;
        end else if (grant_vec[REQ_INC]) begin
            prefer_dec_next = 1'b1;
            if (level_reg != MAX_L) begin
                level_next = level_reg + LEVEL_W'(1);
            end
        end else if (grant_vec[REQ_DEC]) begin
            prefer_dec_next = 1'b0;
            if (level_reg != '0) begin
                level_next = level_reg - LEVEL_W'(1);
            end
        end
    end

    // Blink divider: counts frames while empty, held at zero otherwise
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        blink_next     = blink_reg;
        if (level_reg != '0) begin
            blink_cnt_next = '0;
            blink_next     = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_reg == CNT_LAST) begin
                blink_cnt_next = '0;
                blink_next     = ~blink_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops any outstanding requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            winner_reg     <= '0;
            pending_reg    <= '0;
            prefer_dec_reg <= 1'b0;
            level_reg      <= INIT_L;
            blink_cnt_reg  <= '0;
            blink_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            winner_reg     <= winner_next;
            pending_reg    <= pending_next;
            prefer_dec_reg <= prefer_dec_next;
            level_reg      <= level_next;
            blink_cnt_reg  <= blink_cnt_next;
            blink_reg      <= blink_next;
        end
    end

    assign bus.water_level = level_reg;
    assign bus.pending     = pending_reg;
    assign bus.grant       = grant_vec;
    assign bus.frame_tick  = frame_tick;
    assign bus.empty       = (level_reg == '0);
    assign bus.blink       = blink_reg;

endmodule

// File: tb/tb_level_update_scheduler.sv
// Bench for level_update_scheduler: a table of per-frame request patterns
// with hand-derived grant/level results, a grant scoreboard, and a few
// hand-written sequences (set-wins on commit, blink, reset mid-ARB).
module tb_level_update_scheduler;
    import level_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic vsync = 1'b1;

    always #5 clk = ~clk;

    level_update_scheduler_if bus();

    level_update_scheduler #(
        .MAX_LEVEL    (15),
        .INIT_LEVEL   (0),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int tick_count = 0;

    typedef struct {
        logic [2:0] grant;
        logic [3:0] level;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        int         n;
        logic [2:0] pend;
        logic [2:0] grant;
        logic [3:0] level;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t tbl[$];
    logic       lvl_check_pend = 1'b0;
    logic [3:0] lvl_check_val  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [2:0] req, input int n, input logic [2:0] pend,
                                input logic [2:0] grant, input logic [3:0] level);
        vec_t v;
        v.req = req; v.n = n; v.pend = pend; v.grant = grant; v.level = level;
        tbl.push_back(v);
    endfunction

    // Scoreboard: every grant pops one expectation; level checked next cycle
    always @(negedge clk) begin
        if (lvl_check_pend) begin
            check("sb_level", 32'(bus.water_level), 32'(lvl_check_val));
            lvl_check_pend = 1'b0;
        end
        if (bus.frame_tick) tick_count++;
        if (bus.grant != 3'b000) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_grant: got %b expected none", bus.grant);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_grant", 32'(bus.grant), 32'(sb_e.grant));
                lvl_check_pend = 1'b1;
                lvl_check_val  = sb_e.level;
            end
        end
    end

    task automatic set_req(input logic [2:0] req);
        bus.req_inc = req[0];
        bus.req_dec = req[1];
        bus.req_clr = req[2];
    endtask

    task automatic pulse(input logic [2:0] req, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            set_req(req);
            @(posedge clk); #1;
            set_req(3'b000);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (bus.frame_tick) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no frame_tick expected one within 12 cycles");
        end
    endtask

    task automatic push_exp(input logic [2:0] g, input logic [3:0] l);
        exp_t e;
        e.grant = g;
        e.level = l;
        sb_q.push_back(e);
    endtask

    // One vsync frame: tick at N, ARB at N+1, grant at N+2, level at N+3
    task automatic run_frame(input logic [2:0] exp_grant, input logic [3:0] exp_level,
                             input int exp_blink);
        bit ok;
        if (exp_grant != 3'b000) push_exp(exp_grant, exp_level);
        @(posedge clk); #1;
        vsync = 1'b0;
        wait_tick(ok);
        if (ok) begin
            @(negedge clk);
            check("arb_no_grant", 32'(bus.grant), 32'd0);
            if (exp_blink >= 0) check("blink", 32'(bus.blink), 32'(exp_blink));
            @(negedge clk);
            check("commit_grant", 32'(bus.grant), 32'(exp_grant));
            @(negedge clk);
            check("level", 32'(bus.water_level), 32'(exp_level));
            check("empty", 32'(bus.empty), 32'(exp_level == 4'd0));
            check("grant_one_cycle", 32'(bus.grant), 32'd0);
        end
        $display("frame: grant=%b level=%0d pending=%b empty=%b blink=%b",
                 exp_grant, bus.water_level, bus.pending, bus.empty, bus.blink);
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int t0;
        set_req(3'b000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_level",      32'(bus.water_level), 32'd0);
        check("rst_pending",    32'(bus.pending),     32'd0);
        check("rst_grant",      32'(bus.grant),       32'd0);
        check("rst_frame_tick", 32'(bus.frame_tick),  32'd0);
        check("rst_blink",      32'(bus.blink),       32'd0);
        check("rst_empty",      32'(bus.empty),       32'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // {req, pulses, pending before vsync, grant, level after commit}
        for (int i = 0; i < 3; i++) add(3'b000, 0, 3'b000, 3'b000, 4'd0);
        add(3'b001, 5, 3'b001, 3'b001, 4'd1);
        for (int l = 2; l <= 8; l++) add(3'b001, 1, 3'b001, 3'b001, 4'(l));
        add(3'b010, 1, 3'b010, 3'b010, 4'd7);
        add(3'b011, 1, 3'b011, 3'b001, 4'd8);
        add(3'b011, 1, 3'b011, 3'b010, 4'd7);
        add(3'b011, 1, 3'b011, 3'b001, 4'd8);
        add(3'b011, 1, 3'b011, 3'b010, 4'd7);
        add(3'b000, 0, 3'b001, 3'b001, 4'd8);
        add(3'b001, 1, 3'b001, 3'b001, 4'd9);
        add(3'b101, 1, 3'b101, 3'b100, 4'd0);
        add(3'b000, 0, 3'b001, 3'b001, 4'd1);
        add(3'b010, 1, 3'b010, 3'b010, 4'd0);
        add(3'b010, 1, 3'b010, 3'b010, 4'd0);
        for (int l = 1; l <= 15; l++) add(3'b001, 1, 3'b001, 3'b001, 4'(l));
        add(3'b001, 1, 3'b001, 3'b001, 4'd15);

        for (int i = 0; i < tbl.size(); i++) begin
            pulse(tbl[i].req, tbl[i].n);
            @(negedge clk);
            check("pending_before", 32'(bus.pending), 32'(tbl[i].pend));
            run_frame(tbl[i].grant, tbl[i].level, -1);
            if (i == 2) check("idle_ticks", 32'(tick_count), 32'd3);
        end

        // Pour request landing exactly on the commit edge stays pending
        pulse(3'b001, 1);
        push_exp(3'b001, 4'd15);
        @(posedge clk); #1;
        vsync = 1'b0;
        wait_tick(ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_inc = 1'b1;
        @(negedge clk);
        check("setwin_grant", 32'(bus.grant), 32'b001);
        @(posedge clk); #1;
        bus.req_inc = 1'b0;
        @(negedge clk);
        check("setwin_pending", 32'(bus.pending), 32'b001);
        check("setwin_level", 32'(bus.water_level), 32'd15);
        $display("frame: set-wins grant=001 level=%0d pending=%b", bus.water_level, bus.pending);
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_frame(3'b001, 4'd15, -1);

        // Clear, then blink toggles every second frame while empty
        pulse(3'b100, 1);
        run_frame(3'b100, 4'd0, -1);
        run_frame(3'b000, 4'd0, 0);
        run_frame(3'b000, 4'd0, 1);
        run_frame(3'b000, 4'd0, 1);
        run_frame(3'b000, 4'd0, 0);

        // Leaving empty forces blink low
        pulse(3'b001, 1);
        run_frame(3'b001, 4'd1, -1);
        check("blink_forced_low", 32'(bus.blink), 32'd0);

        // Asynchronous reset in the ARB cycle
        pulse(3'b001, 1);
        @(posedge clk); #1;
        vsync = 1'b0;
        wait_tick(ok);
        @(posedge clk); #1;
        check("pre_reset_pending", 32'(bus.pending), 32'b001);
        reset = 1'b0;
        vsync = 1'b1;
        #1;
        check("arst_level",      32'(bus.water_level), 32'd0);
        check("arst_pending",    32'(bus.pending),     32'd0);
        check("arst_grant",      32'(bus.grant),       32'd0);
        check("arst_frame_tick", 32'(bus.frame_tick),  32'd0);
        check("arst_blink",      32'(bus.blink),       32'd0);
        check("arst_empty",      32'(bus.empty),       32'd1);
        $display("reset mid-ARB: level=%0d pending=%b grant=%b", bus.water_level, bus.pending, bus.grant);
        @(posedge clk); #1;
        reset = 1'b1;
        t0 = tick_count;
        repeat (4) @(posedge clk);
        #1;
        check("no_tick_after_reset", 32'(tick_count), 32'(t0));
        run_frame(3'b000, 4'd0, -1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
